// File: rtl/snitch_asic_dw_serializer.sv
// rtl/snitch_asic_dw_serializer.sv - MemDW core request to AsicDW-beat link serializer with read reassembly
module snitch_asic_dw_serializer #(
    parameter int unsigned AsicAW    = 8,
    parameter int unsigned AsicDW    = 4,
    parameter int unsigned MemDW     = 32,
    parameter int unsigned Stages    = MemDW / AsicDW,
    parameter int unsigned StrbWidth = MemDW / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AsicAW-1:0]    core_req_addr_i,
    input  logic [MemDW-1:0]     core_req_data_i,
    input  logic                 core_req_write_i,
    input  logic [StrbWidth-1:0] core_req_wstrb_i,
    input  logic                 core_req_valid_i,
    output logic                 core_req_ready_o,
    output logic [MemDW-1:0]     core_rsp_data_o,
    output logic                 core_rsp_valid_o,
    input  logic                 core_rsp_ready_i,
    output logic [AsicAW-1:0]    asic_req_addr_o,
    output logic [AsicDW-1:0]    asic_req_data_o,
    output logic                 asic_req_write_o,
    output logic                 asic_req_wstrb_o,
    output logic                 asic_req_valid_o,
    input  logic                 asic_req_ready_i,
    input  logic [AsicDW-1:0]    asic_rsp_data_i,
    input  logic                 asic_rsp_valid_i,
    output logic                 asic_rsp_ready_o
);

    localparam int unsigned CntW = (Stages > 1) ? $clog2(Stages) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(Stages - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RSP,
        RESP
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [CntW-1:0]       cnt_q;
    logic [AsicAW-1:0]     addr_q;
    logic                  write_q;
    logic [MemDW-1:0]      data_q;
    logic [StrbWidth-1:0]  wstrb_q;
    logic [MemDW-1:0]      rsp_q;
    logic                  last_beat;
    logic                  send_active;
    logic [StrbWidth-1:0]  strb_shift;

    // Reads occupy a single request beat; writes stream all Stages beats.
    assign last_beat   = !write_q || (cnt_q == LastBeat);
    assign send_active = (state_q == SEND);

    // Bring the strobe of the byte holding beat k up to the MSB position.
    assign strb_shift = wstrb_q << ((int'(cnt_q) * AsicDW) / 8);

    assign asic_req_addr_o  = send_active ? addr_q : '0;
    assign asic_req_write_o = send_active & write_q;
    assign asic_req_data_o  = send_active ? data_q[MemDW-1 -: AsicDW] : '0;
    assign asic_req_wstrb_o = send_active & strb_shift[StrbWidth-1];
    assign core_rsp_data_o  = rsp_q;

    always_comb begin
        state_d          = state_q;
        core_req_ready_o = 1'b0;
        asic_req_valid_o = 1'b0;
        asic_rsp_ready_o = 1'b0;
        core_rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                core_req_ready_o = 1'b1;
                if (core_req_valid_i) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                asic_req_valid_o = 1'b1;
                if (asic_req_ready_i && last_beat) begin
                    state_d = write_q ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                asic_rsp_ready_o = 1'b1;
                if (asic_rsp_valid_i && (cnt_q == LastBeat)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                core_rsp_valid_o = 1'b1;
                if (core_rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            data_q  <= '0;
            wstrb_q <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (core_req_valid_i) begin
                        addr_q  <= core_req_addr_i;
                        write_q <= core_req_write_i;
                        data_q  <= core_req_write_i ? core_req_data_i : '0;
                        wstrb_q <= core_req_write_i ? core_req_wstrb_i : '0;
                        cnt_q   <= '0;
                    end
                end
                SEND: begin
                    if (asic_req_ready_i) begin
                        data_q <= data_q << AsicDW;
                        cnt_q  <= last_beat ? '0 : cnt_q + 1'b1;
                    end
                end
                WAIT_RSP: begin
                    // MSB-first arrival: each new beat enters at the bottom.
                    if (asic_rsp_valid_i) begin
                        rsp_q <= MemDW'({rsp_q, asic_rsp_data_i});
                        cnt_q <= (cnt_q == LastBeat) ? '0 : cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snitch_asic_dw_serializer.sv
// tb/tb_snitch_asic_dw_serializer.sv - randomized self-checking bench for snitch_asic_dw_serializer
module tb_snitch_asic_dw_serializer;

    localparam int AW     = 8;
    localparam int ADW    = 4;
    localparam int MDW    = 32;
    localparam int STAGES = MDW / ADW;
    localparam int SW     = MDW / 8;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [AW-1:0]  core_req_addr_i;
    logic [MDW-1:0] core_req_data_i;
    logic           core_req_write_i;
    logic [SW-1:0]  core_req_wstrb_i;
    logic           core_req_valid_i;
    logic           core_req_ready_o;
    logic [MDW-1:0] core_rsp_data_o;
    logic           core_rsp_valid_o;
    logic           core_rsp_ready_i;
    logic [AW-1:0]  asic_req_addr_o;
    logic [ADW-1:0] asic_req_data_o;
    logic           asic_req_write_o;
    logic           asic_req_wstrb_o;
    logic           asic_req_valid_o;
    logic           asic_req_ready_i;
    logic [ADW-1:0] asic_rsp_data_i;
    logic           asic_rsp_valid_i;
    logic           asic_rsp_ready_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    snitch_asic_dw_serializer dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .core_req_addr_i  (core_req_addr_i),
        .core_req_data_i  (core_req_data_i),
        .core_req_write_i (core_req_write_i),
        .core_req_wstrb_i (core_req_wstrb_i),
        .core_req_valid_i (core_req_valid_i),
        .core_req_ready_o (core_req_ready_o),
        .core_rsp_data_o  (core_rsp_data_o),
        .core_rsp_valid_o (core_rsp_valid_o),
        .core_rsp_ready_i (core_rsp_ready_i),
        .asic_req_addr_o  (asic_req_addr_o),
        .asic_req_data_o  (asic_req_data_o),
        .asic_req_write_o (asic_req_write_o),
        .asic_req_wstrb_o (asic_req_wstrb_o),
        .asic_req_valid_o (asic_req_valid_o),
        .asic_req_ready_i (asic_req_ready_i),
        .asic_rsp_data_i  (asic_rsp_data_i),
        .asic_rsp_valid_i (asic_rsp_valid_i),
        .asic_rsp_ready_o (asic_rsp_ready_o)
    );

    // Expected link beat k of a write: {addr, write, nibble, strobe}.
    function automatic logic [13:0] exp_wbeat(input logic [7:0] a, input logic [31:0] d,
                                              input logic [3:0] s, input int k);
        logic [31:0] nib;
        logic [3:0]  sb;
        nib = (d >> (MDW - ADW * (k + 1))) & 32'hF;
        sb  = s >> (SW - 1 - (k * ADW) / 8);
        return {a, 1'b1, nib[3:0], sb[0]};
    endfunction

    function automatic logic [49:0] out_vec();
        return {core_req_ready_o, core_rsp_data_o, core_rsp_valid_o, asic_req_addr_o,
                asic_req_data_o, asic_req_write_o, asic_req_wstrb_o, asic_req_valid_o,
                asic_rsp_ready_o};
    endfunction

    // mode: 0 link always ready, 1 ready toggles 1,0,1,..., 2 random ready
    task automatic run_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int mode, input bit unsol, input string name);
        logic [13:0] got[$];
        logic [13:0] prev;
        logic [13:0] cur;
        logic [13:0] want;
        bit          prev_stall;
        bit          rdy;
        int          idle_cyc;
        prev       = '0;
        prev_stall = 1'b0;
        idle_cyc   = 0;
        @(negedge clk);
        total++;
        if (core_req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s req_ready_idle: got %b want 1", name, core_req_ready_o);
        end
        core_req_valid_i = 1'b1;
        core_req_addr_i  = a;
        core_req_data_i  = d;
        core_req_write_i = 1'b1;
        core_req_wstrb_i = s;
        @(negedge clk);
        core_req_valid_i = 1'b0;
        core_req_data_i  = $urandom;
        for (int c = 1; c <= 200; c++) begin
            if (core_req_ready_o === 1'b1) begin
                idle_cyc = c;
                break;
            end
            if (unsol) begin
                total++;
                if (asic_rsp_ready_o !== 1'b0 || core_rsp_valid_o !== 1'b0) begin
                    bad++;
                    $display("FAIL %s unsolicited_send: got rsp_ready=%b core_rsp_valid=%b want 0 0",
                             name, asic_rsp_ready_o, core_rsp_valid_o);
                end
                asic_rsp_valid_i = 1'b1;
                asic_rsp_data_i  = 4'($urandom);
            end
            cur = {asic_req_addr_o, asic_req_write_o, asic_req_data_o, asic_req_wstrb_o};
            if (prev_stall) begin
                total++;
                if (cur !== prev) begin
                    bad++;
                    $display("FAIL %s beat_hold: got %h want %h", name, cur, prev);
                end
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 1) : 1'($urandom_range(0, 1));
            asic_req_ready_i = rdy;
            if (asic_req_valid_o === 1'b1) begin
                if (rdy) got.push_back(cur);
                prev_stall = !rdy;
                prev       = cur;
            end else begin
                prev_stall = 1'b0;
            end
            @(negedge clk);
        end
        asic_req_ready_i = 1'b0;
        asic_rsp_valid_i = 1'b0;
        total++;
        if (idle_cyc == 0) begin
            bad++;
            $display("FAIL %s write_timeout: got no return to idle want idle within 200 cycles", name);
        end
        if (mode == 0) begin
            total++;
            if (idle_cyc != STAGES + 1) begin
                bad++;
                $display("FAIL %s idle_latency: got %0d want %0d", name, idle_cyc, STAGES + 1);
            end
        end
        total++;
        if (got.size() != STAGES) begin
            bad++;
            $display("FAIL %s beat_count: got %0d want %0d", name, got.size(), STAGES);
        end
        for (int k = 0; k < STAGES && k < got.size(); k++) begin
            want = exp_wbeat(a, d, s, k);
            total++;
            if (got[k] !== want) begin
                bad++;
                $display("FAIL %s beat%0d: got %h want %h", name, k, got[k], want);
            end
        end
    endtask

    task automatic run_read(input logic [7:0] a, input logic [31:0] w, input int gmax,
                            input int hold, input string name);
        logic [13:0] got[$];
        logic [3:0]  beats[STAGES];
        logic [31:0] exp;
        bit          rdy;
        bit          waiting;
        waiting = 1'b0;
        exp     = '0;
        for (int k = 0; k < STAGES; k++) begin
            beats[k] = 4'(w >> (MDW - ADW * (k + 1)));
            exp      = (exp << ADW) | 32'(beats[k]);
        end
        @(negedge clk);
        total++;
        if (core_req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s req_ready_idle: got %b want 1", name, core_req_ready_o);
        end
        core_req_valid_i = 1'b1;
        core_req_addr_i  = a;
        core_req_data_i  = $urandom;
        core_req_write_i = 1'b0;
        core_req_wstrb_i = 4'($urandom);
        @(negedge clk);
        core_req_valid_i = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (asic_rsp_ready_o === 1'b1) begin
                waiting = 1'b1;
                break;
            end
            rdy = 1'($urandom_range(0, 1));
            asic_req_ready_i = rdy;
            if (asic_req_valid_o === 1'b1 && rdy)
                got.push_back({asic_req_addr_o, asic_req_write_o, asic_req_data_o, asic_req_wstrb_o});
            @(negedge clk);
        end
        asic_req_ready_i = 1'b0;
        total++;
        if (!waiting || got.size() != 1) begin
            bad++;
            $display("FAIL %s read_req_beats: got %0d beats waiting=%b want 1 beat waiting=1",
                     name, got.size(), waiting);
        end else begin
            total++;
            if (got[0] !== {a, 1'b0, 4'h0, 1'b0}) begin
                bad++;
                $display("FAIL %s read_req_beat: got %h want %h", name, got[0], {a, 6'h0});
            end
        end
        for (int k = 0; k < STAGES; k++) begin
            repeat ($urandom_range(0, gmax)) begin
                asic_rsp_valid_i = 1'b0;
                asic_rsp_data_i  = 4'($urandom);
                @(negedge clk);
            end
            asic_rsp_valid_i = 1'b1;
            asic_rsp_data_i  = beats[k];
            total++;
            if (asic_rsp_ready_o !== 1'b1) begin
                bad++;
                $display("FAIL %s rsp_ready_beat%0d: got %b want 1", name, k, asic_rsp_ready_o);
            end
            @(negedge clk);
        end
        asic_rsp_valid_i = 1'b0;
        total++;
        if (asic_rsp_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL %s rsp_ready_after: got %b want 0", name, asic_rsp_ready_o);
        end
        for (int h = 0; h < hold; h++) begin
            total++;
            if (core_rsp_valid_o !== 1'b1 || core_rsp_data_o !== exp) begin
                bad++;
                $display("FAIL %s core_rsp_cyc%0d: got valid=%b data=%h want valid=1 data=%h",
                         name, h, core_rsp_valid_o, core_rsp_data_o, exp);
            end
            core_rsp_ready_i = (h == hold - 1);
            @(negedge clk);
        end
        core_rsp_ready_i = 1'b0;
        total++;
        if (core_rsp_valid_o !== 1'b0 || core_req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s back_to_idle: got rsp_valid=%b req_ready=%b want 0 1",
                     name, core_rsp_valid_o, core_req_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i            = 1'b1;
        core_req_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (out_vec() !== {1'b1, 49'h0}) begin
            bad++;
            $display("FAIL reset_outputs: got %h want %h", out_vec(), {1'b1, 49'h0});
        end
        core_req_valid_i = 1'b0;
        rst_i            = 1'b0;
    endtask

    task automatic test_write_basic();
        run_write(8'h5A, 32'hDEADBEEF, 4'hF, 0, 1'b0, "write_deadbeef");
        run_write(8'h11, 32'h12345678, 4'b0101, 0, 1'b0, "write_strb0101");
    endtask

    task automatic test_backpressure();
        run_write(8'hA7, 32'h0F1E2D3C, 4'b1001, 1, 1'b0, "write_toggle_ready");
    endtask

    task automatic test_read();
        run_read(8'h33, 32'h12345678, 3, 3, "read_12345678");
    endtask

    task automatic test_unsolicited();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            asic_rsp_valid_i = 1'b1;
            asic_rsp_data_i  = 4'($urandom);
            total++;
            if (asic_rsp_ready_o !== 1'b0 || core_rsp_valid_o !== 1'b0 || core_req_ready_o !== 1'b1) begin
                bad++;
                $display("FAIL unsolicited_idle: got rsp_ready=%b rsp_valid=%b req_ready=%b want 0 0 1",
                         asic_rsp_ready_o, core_rsp_valid_o, core_req_ready_o);
            end
        end
        asic_rsp_valid_i = 1'b0;
        run_write(8'h3C, 32'h89ABCDEF, 4'b1110, 1, 1'b1, "write_unsolicited");
        run_read(8'h44, 32'hA5C3F00F, 2, 1, "read_after_unsolicited");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        core_req_valid_i = 1'b1;
        core_req_addr_i  = 8'h77;
        core_req_data_i  = 32'h9ABC1234;
        core_req_write_i = 1'b1;
        core_req_wstrb_i = 4'hF;
        @(negedge clk);
        core_req_valid_i = 1'b0;
        asic_req_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i            = 1'b1;
        asic_req_ready_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        total++;
        if (out_vec() !== {1'b1, 49'h0}) begin
            bad++;
            $display("FAIL reset_mid_outputs: got %h want %h", out_vec(), {1'b1, 49'h0});
        end
        run_write(8'h21, 32'hCAFEF00D, 4'hF, 0, 1'b0, "write_after_reset");
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            if ($urandom_range(0, 1) == 1)
                run_write(8'($urandom), d, 4'($urandom), 2, 1'b0, "rand_write");
            else
                run_read(8'($urandom), d, 3, int'($urandom_range(1, 3)), "rand_read");
        end
    endtask

    initial begin
        rst_i            = 1'b1;
        core_req_addr_i  = '0;
        core_req_data_i  = '0;
        core_req_write_i = 1'b0;
        core_req_wstrb_i = '0;
        core_req_valid_i = 1'b0;
        core_rsp_ready_i = 1'b0;
        asic_req_ready_i = 1'b0;
        asic_rsp_data_i  = '0;
        asic_rsp_valid_i = 1'b0;
        test_reset();
        test_write_basic();
        test_backpressure();
        test_read();
        test_unsolicited();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snitch_asic_dw_serializer.md
Name: snitch_asic_dw_serializer

Overview:
ASIC-side counterpart of the eFPGA width converter: accepts one full-width (MemDW) memory request from the Snitch core and serializes it into AsicDW-bit beats on the narrow ASIC↔eFPGA link. Read responses arrive as AsicDW-bit beats and are re-assembled into one MemDW word for the core. Beat order is MSB-first in both directions. At most one transaction is in flight.

Parameters:
AsicAW, 8, link/core word-address width (address is not serialized).
AsicDW, 4, link data width per beat; power of two, ≤8, divides MemDW.
MemDW, 32, core-side data width.
Stages, MemDW/AsicDW, derived (beats per word); do not override.
StrbWidth, MemDW/8, derived (core byte strobes); do not override.

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
core_req_addr_i  in  AsicAW  word address
core_req_data_i  in  MemDW  write data
core_req_write_i  in  1  1=write, 0=read
core_req_wstrb_i  in  StrbWidth  byte strobes (writes only)
core_req_valid_i  in  1  request valid
core_req_ready_o  out  1  request accepted
core_rsp_data_o  out  MemDW  assembled read data
core_rsp_valid_o  out  1  read response valid
core_rsp_ready_i  in  1  core accepts response
asic_req_addr_o  out  AsicAW  link address, constant for all beats of a transaction
asic_req_data_o  out  AsicDW  beat data
asic_req_write_o  out  1  write flag, constant across beats
asic_req_wstrb_o  out  1  per-beat strobe
asic_req_valid_o  out  1  beat valid
asic_req_ready_i  in  1  link accepts beat
asic_rsp_data_i  in  AsicDW  response beat
asic_rsp_valid_i  in  1  response beat valid
asic_rsp_ready_o  out  1  serializer accepts response beat

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, beat counter=0, all data/addr/strobe registers=0; next cycle all outputs 0 except core_req_ready_o=1. Reset mid-operation abandons the transaction and drops partial data; no beat is completed afterwards.
- FSM states: IDLE, SEND, WAIT_RSP, RESP.
- IDLE: core_req_ready_o=1 (decoded from state only). On core_req_valid_i: capture addr, data, write, wstrb; counter=0; go to SEND. Accept cycle T → first beat valid at T+1.
- SEND: asic_req_valid_o=1; addr/write from capture regs; data = data_q[MemDW-1-k*AsicDW -: AsicDW] for beat k (implement as left-shift register). wstrb_o = wstrb_q[StrbWidth-1-(k*AsicDW)/8]. Outputs held stable while asic_req_ready_i=0. On handshake: k++.
  - Write: Stages beats. After handshake of beat Stages-1 → IDLE. Writes are posted: no core response generated.
  - Read: exactly one beat, data=0, wstrb=0. After handshake → WAIT_RSP.
- WAIT_RSP: asic_rsp_ready_o=1. Each asic_rsp_valid_i beat shifts in at LSB: rsp_q = {rsp_q[MemDW-AsicDW-1:0], asic_rsp_data_i}; counter++. After beat Stages-1 accepted → RESP. Beats may have arbitrary gaps.
- RESP: core_rsp_valid_o=1, core_rsp_data_o=rsp_q, stable until core_rsp_ready_i; on handshake → IDLE (next request accepted one cycle later, earliest).
- asic_rsp_ready_o=0 outside WAIT_RSP; unsolicited response beats are ignored, no state change.
- core_req_ready_o=0 in SEND/WAIT_RSP/RESP; core request inputs ignored then.
- Counter width $clog2(Stages) (min 1); wraps to 0 at end of each phase.
- asic_req_* driven from registers and capture regs; no combinational path from asic_req_ready_i to asic_req_valid_o.

Test Plan:
1. Write addr 0x5A, data 0xDEADBEEF, wstrb 0xF, link ready=1 → beats D,E,A,D,B,E,E,F on cycles T+1..T+8, addr 0x5A, write=1, wstrb=1 each; core_req_ready_o high again at T+9.
2. Write data 0x12345678, wstrb 0b0101 → per-beat wstrb 0,0,1,1,0,0,1,1; data 1..8.
3. Write with asic_req_ready_i toggling 1,0,1,0… → each beat held stable until accepted; exactly 8 beats, none duplicated or dropped.
4. Read addr 0x33 → one beat (write=0, data=0); link returns 1,2,3,4,5,6,7,8 with random gaps → core_rsp_valid_o=1, data 0x12345678, held 3 cycles until core_rsp_ready_i, then IDLE.
5. asic_rsp_valid_i=1 in IDLE and SEND → asic_rsp_ready_o=0, no core_rsp_valid_o, state unchanged.
6. rst_i after 3 write beats → next cycle asic_req_valid_o=0, IDLE; new write 0xCAFEF00D starts at beat C.
